// File: rtl/arb_pkg.sv
// Shared types and constants for the priority arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_enc_n.sv
// Combinational highest-set-index encoder with a found flag.
module prio_enc_n #(
  parameter  int N      = 16,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic [N-1:0]      req_i,
  output logic [ADDR_W-1:0] idx_o,
  output logic              found_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o   = ADDR_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Fixed-priority / round-robin arbiter with a sticky, registered grant.
module priority_arbiter
  import arb_pkg::*;
#(
  parameter  int N      = 16,
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic              mode,
  input  logic              grant_ready,
  output logic              grant_valid,
  output logic [ADDR_W-1:0] grant_addr,
  output logic [N-1:0]      grant_onehot,
  output logic              busy
);

  arb_state_e        state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [N-1:0]      onehot_q;

  logic              hs;
  logic [N-1:0]      below, req_masked;
  logic [ADDR_W-1:0] m_idx, f_idx, win_addr;
  logic              m_found, f_found;
  logic [N-1:0]      win_oh;

  assign hs = (state_q == GRANT) && grant_ready;

  // Winner is computed against the pointer as it will be after this edge.
  assign ptr_d = hs ? addr_q : ptr_q;

  for (genvar g = 0; g < N; g++) begin : g_mask
    assign below[g] = (ADDR_W'(g) < ptr_d);
  end
  assign req_masked = req & below;

  prio_enc_n #(.N(N)) u_enc_masked (
    .req_i   (req_masked),
    .idx_o   (m_idx),
    .found_o (m_found)
  );

  prio_enc_n #(.N(N)) u_enc_full (
    .req_i   (req),
    .idx_o   (f_idx),
    .found_o (f_found)
  );

  // Unmasked search doubles as fixed priority and as the round-robin wrap.
  assign win_addr = (mode == MODE_RR && m_found) ? m_idx : f_idx;

  always_comb begin
    win_oh           = '0;
    win_oh[win_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      addr_q   <= '0;
      onehot_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (f_found) begin
            state_q  <= GRANT;
            addr_q   <= win_addr;
            onehot_q <= win_oh;
          end
        end
        GRANT: begin
          if (grant_ready) begin
            ptr_q <= ptr_d;
            if (f_found) begin
              addr_q   <= win_addr;
              onehot_q <= win_oh;
            end else begin
              state_q  <= IDLE;
              addr_q   <= '0;
              onehot_q <= '0;
            end
          end
        end
        default: begin
          state_q  <= IDLE;
          addr_q   <= '0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign busy         = (state_q == GRANT);
  assign grant_addr   = addr_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed + randomized check of priority_arbiter at N=16 and N=5 against a queue-free reference model.
module tb_priority_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req16;
  logic [4:0]  req5;
  logic        mode, rdy;

  logic        gv16, busy16;
  logic [3:0]  ga16;
  logic [15:0] oh16;
  logic        gv5, busy5;
  logic [2:0]  ga5;
  logic [4:0]  oh5;

  always #5 clk = ~clk;

  priority_arbiter #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .req(req16), .mode(mode), .grant_ready(rdy),
    .grant_valid(gv16), .grant_addr(ga16), .grant_onehot(oh16), .busy(busy16)
  );

  priority_arbiter #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .req(req5), .mode(mode), .grant_ready(rdy),
    .grant_valid(gv5), .grant_addr(ga5), .grant_onehot(oh5), .busy(busy5)
  );

  int cmp = 0;
  int bad = 0;

  // Reference state per instance: 0 -> N=16, 1 -> N=5.
  bit mv[2];
  int ma[2];
  int mp[2];

  function automatic int win(input logic [63:0] r, input int n, input int p, input logic m);
    int idx;
    if (!m) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        idx = (p - k + n) % n;
        if (r[idx]) return idx;
      end
    end
    return 0;
  endfunction

  task automatic mstep(input int j, input int n, input logic [63:0] r);
    if (!mv[j]) begin
      if (r != 0) begin
        mv[j] = 1'b1;
        ma[j] = win(r, n, mp[j], mode);
      end
    end else if (rdy) begin
      mp[j] = ma[j];
      if (r != 0) ma[j] = win(r, n, mp[j], mode);
      else begin
        mv[j] = 1'b0;
        ma[j] = 0;
      end
    end
  endtask

  task automatic mreset();
    for (int j = 0; j < 2; j++) begin
      mv[j] = 1'b0; ma[j] = 0; mp[j] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    cmp++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_all();
    chk("v16",  64'(gv16),   64'(mv[0]));
    chk("b16",  64'(busy16), 64'(mv[0]));
    chk("a16",  64'(ga16),   64'(ma[0]));
    chk("oh16", 64'(oh16),   mv[0] ? (64'd1 << ma[0]) : 64'd0);
    chk("v5",   64'(gv5),    64'(mv[1]));
    chk("b5",   64'(busy5),  64'(mv[1]));
    chk("a5",   64'(ga5),    64'(ma[1]));
    chk("oh5",  64'(oh5),    mv[1] ? (64'd1 << ma[1]) : 64'd0);
    chk("a5_range", 64'(ga5 <= 3'd4), 64'd1);
  endtask

  task automatic cyc(input logic [15:0] r16, input logic [4:0] r5, input logic m, input logic rd);
    req16 = r16; req5 = r5; mode = m; rdy = rd;
    @(posedge clk);
    mstep(0, 16, 64'(req16));
    mstep(1, 5, 64'(req5));
    #1 check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mreset();
    #1 check_all();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int exp34[5] = '{15, 10, 5, 0, 15};
  int exp37[6] = '{4, 3, 2, 1, 0, 4};

  initial begin
    rst = 1'b0; req16 = '0; req5 = '0; mode = 1'b0; rdy = 1'b0;
    mreset();
    #1 rst = 1'b1;
    #1 check_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // Fixed priority, sticky grant while not ready.
    cyc(16'h8001, 5'h00, 1'b0, 1'b0);
    chk("r33_first", 64'(ga16), 64'd15);
    for (int i = 0; i < 3; i++) begin
      cyc(16'h0001, 5'h00, 1'b0, 1'b0);
      chk("r33_hold", 64'(ga16), 64'd15);
    end
    cyc(16'h0001, 5'h00, 1'b0, 1'b1);
    chk("r33_next", 64'(ga16), 64'd0);
    cyc(16'h0000, 5'h00, 1'b0, 1'b1);
    chk("r33_idle", 64'(gv16), 64'd0);

    // Round-robin rotation over 0x8421.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(16'h8421, 5'h00, 1'b1, 1'b1);
      chk("r34_seq", 64'(ga16), 64'(exp34[i]));
    end

    // Idle with no requests, then a single requester.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(16'h0000, 5'h00, 1'b0, 1'b0);
      chk("r35_idle_v", 64'(gv16), 64'd0);
      chk("r35_idle_a", 64'(ga16), 64'd0);
    end
    cyc(16'h0010, 5'h00, 1'b0, 1'b0);
    chk("r35_grant", 64'(ga16), 64'd4);
    cyc(16'h0000, 5'h00, 1'b0, 1'b1);
    chk("r35_drop", 64'(gv16), 64'd0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cyc(16'h0080, 5'h00, 1'b1, 1'b0);
    chk("r36_grant", 64'(ga16), 64'd7);
    #2 rst = 1'b1;
    mreset();
    #1 check_all();
    chk("r36_async_v", 64'(gv16), 64'd0);
    chk("r36_async_oh", 64'(oh16), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(16'hFFFF, 5'h00, 1'b1, 1'b0);
    chk("r36_after", 64'(ga16), 64'd15);

    // N=5 round-robin wrap.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(16'h0000, 5'h1F, 1'b1, 1'b1);
      chk("r37_seq", 64'(ga5), 64'(exp37[i]));
    end

    // Mode toggled while the grant is held.
    do_reset();
    cyc(16'h8001, 5'h00, 1'b0, 1'b0);
    chk("r38_fixed", 64'(ga16), 64'd15);
    cyc(16'h8001, 5'h00, 1'b1, 1'b0);
    chk("r38_held", 64'(ga16), 64'd15);
    cyc(16'h8001, 5'h00, 1'b1, 1'b1);
    chk("r38_rr_next", 64'(ga16), 64'd0);

    // Randomized traffic with occasional reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [15:0] r16;
      logic [4:0]  r5;
      r16 = 16'($urandom);
      r5  = 5'($urandom);
      if ($urandom_range(0, 3) == 0) r16 = r16 & 16'($urandom);
      if ($urandom_range(0, 7) == 0) r16 = '0;
      if ($urandom_range(0, 7) == 0) r5 = '0;
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      cyc(r16, r5, mode, 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 63) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
